// File: rtl/pack_sink.sv
// Receiving endpoint of a node: accepts flits on the ready handshake, reassembles
// packets, checks address/length/sequence and keeps counters plus sticky error flags.
module pack_sink #(
    parameter int DATA_SIZE     = 4,
    parameter int ADDR_SIZE     = 1,
    parameter int ADDR          = 0,
    parameter int MAX_PACK_LEN  = 10,
    parameter int PACKS_TO_RECV = 10,
    parameter int STALL_PERIOD  = 0,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic [DATA_SIZE+1:0] data_i,
    input  logic                 r_ready_in,
    output logic                 wr_ready_out,
    output logic [CNT_W-1:0]     packs_cnt,
    output logic [CNT_W-1:0]     flits_cnt,
    output logic [ADDR_SIZE-1:0] last_src,
    output logic                 err_addr,
    output logic                 err_len,
    output logic                 err_seq,
    output logic                 err_proto,
    output logic                 done
);
    localparam int LW = $clog2(MAX_PACK_LEN + 2);
    localparam logic [LW-1:0]        LEN_MAX   = LW'(MAX_PACK_LEN);
    localparam logic [ADDR_SIZE-1:0] MY_ADDR   = ADDR_SIZE'(ADDR);
    localparam logic [CNT_W-1:0]     PACKS_TGT = CNT_W'(PACKS_TO_RECV);
    localparam logic [1:0]           T_HEAD    = 2'b01;
    localparam logic [1:0]           T_TAIL    = 2'b10;
    localparam logic [1:0]           T_SINGLE  = 2'b11;

    typedef enum logic {IDLE, RECV} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          len_q, len_d;
    logic [DATA_SIZE-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]       packs_q, packs_d, flits_q, flits_d;
    logic [ADDR_SIZE-1:0]   src_q, src_d;
    logic                   err_addr_q, err_addr_d, err_len_q, err_len_d;
    logic                   err_seq_q, err_seq_d, err_proto_q, err_proto_d;
    logic                   done_q, done_d;
    logic                   wr_ready_q;

    logic [1:0]             ftype;
    logic [DATA_SIZE-1:0]   payload;
    logic                   accept;

    assign ftype   = data_i[DATA_SIZE+1:DATA_SIZE];
    assign payload = data_i[DATA_SIZE-1:0];
    assign accept  = r_ready_in & wr_ready_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        exp_d       = exp_q;
        packs_d     = packs_q;
        flits_d     = flits_q;
        src_d       = src_q;
        err_addr_d  = err_addr_q;
        err_len_d   = err_len_q;
        err_seq_d   = err_seq_q;
        err_proto_d = err_proto_q;
        if (accept) begin
            flits_d = flits_q + 1'b1;
            case (ftype)
                T_HEAD, T_SINGLE: begin
                    // a head inside a packet abandons the old one uncounted
                    if (state_q == RECV) err_proto_d = 1'b1;
                    src_d = payload[2*ADDR_SIZE-1:ADDR_SIZE];
                    if (payload[ADDR_SIZE-1:0] != MY_ADDR) err_addr_d = 1'b1;
                    len_d = LW'(1);
                    exp_d = DATA_SIZE'(1);
                    if (ftype == T_SINGLE) begin
                        state_d = IDLE;
                        packs_d = packs_q + 1'b1;
                    end else begin
                        state_d = RECV;
                    end
                end
                default: begin
                    if (state_q == IDLE) begin
                        err_proto_d = 1'b1;
                    end else begin
                        if (len_q >= LEN_MAX) err_len_d = 1'b1;
                        // saturate just above the limit so the length can never wrap
                        if (len_q <= LEN_MAX) len_d = len_q + 1'b1;
                        if (payload != exp_q) err_seq_d = 1'b1;
                        exp_d = exp_q + 1'b1;
                        if (ftype == T_TAIL) begin
                            state_d = IDLE;
                            packs_d = packs_q + 1'b1;
                        end
                    end
                end
            endcase
        end
        done_d = done_q | (packs_d >= PACKS_TGT);
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            exp_q       <= '0;
            packs_q     <= '0;
            flits_q     <= '0;
            src_q       <= '0;
            err_addr_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_seq_q   <= 1'b0;
            err_proto_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            exp_q       <= exp_d;
            packs_q     <= packs_d;
            flits_q     <= flits_d;
            src_q       <= src_d;
            err_addr_q  <= err_addr_d;
            err_len_q   <= err_len_d;
            err_seq_q   <= err_seq_d;
            err_proto_q <= err_proto_d;
            done_q      <= done_d;
        end
    end

    generate
        if (STALL_PERIOD == 0) begin : g_nostall
            assign wr_ready_q = 1'b1;
        end else begin : g_stall
            localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);
            logic [SW-1:0] stall_cnt_q, stall_cnt_d;
            logic          ready_q;

            assign stall_cnt_d = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
            assign wr_ready_q  = ready_q;

            // ready is registered from the next count so it always mirrors the current count
            always_ff @(posedge clk or posedge a_rst) begin
                if (a_rst) begin
                    stall_cnt_q <= '0;
                    ready_q     <= 1'b1;
                end else begin
                    stall_cnt_q <= stall_cnt_d;
                    ready_q     <= (stall_cnt_d != STALL_LAST);
                end
            end
        end
    endgenerate

    assign wr_ready_out = wr_ready_q;
    assign packs_cnt    = packs_q;
    assign flits_cnt    = flits_q;
    assign last_src     = src_q;
    assign err_addr     = err_addr_q;
    assign err_len      = err_len_q;
    assign err_seq      = err_seq_q;
    assign err_proto    = err_proto_q;
    assign done         = done_q;
endmodule

// File: tb/tb_pack_sink.sv
// Scoreboard bench for pack_sink: two instances (no stall / stall with small counters)
// driven by directed and random packet traffic against a packet-level reference model.
module tb_pack_sink;
    logic clk = 1'b0;
    logic a_rst;
    always #5 clk = ~clk;

    logic       rv  [2];
    logic [5:0] dat [2];
    logic       rdy_o [2];
    logic [15:0] packs_a, flits_a;
    logic [3:0]  packs_b, flits_b;
    logic       src_o [2];
    logic       ea_o [2], el_o [2], es_o [2], ep_o [2], dn_o [2];

    pack_sink #(.DATA_SIZE(4), .ADDR_SIZE(1), .ADDR(0), .MAX_PACK_LEN(10),
                .PACKS_TO_RECV(10), .STALL_PERIOD(0), .CNT_W(16)) dut_a (
        .clk(clk), .a_rst(a_rst), .data_i(dat[0]), .r_ready_in(rv[0]),
        .wr_ready_out(rdy_o[0]), .packs_cnt(packs_a), .flits_cnt(flits_a),
        .last_src(src_o[0]), .err_addr(ea_o[0]), .err_len(el_o[0]), .err_seq(es_o[0]),
        .err_proto(ep_o[0]), .done(dn_o[0]));

    pack_sink #(.DATA_SIZE(4), .ADDR_SIZE(1), .ADDR(1), .MAX_PACK_LEN(3),
                .PACKS_TO_RECV(10), .STALL_PERIOD(4), .CNT_W(4)) dut_b (
        .clk(clk), .a_rst(a_rst), .data_i(dat[1]), .r_ready_in(rv[1]),
        .wr_ready_out(rdy_o[1]), .packs_cnt(packs_b), .flits_cnt(flits_b),
        .last_src(src_o[1]), .err_addr(ea_o[1]), .err_len(el_o[1]), .err_seq(es_o[1]),
        .err_proto(ep_o[1]), .done(dn_o[1]));

    function automatic int pmax(int i);   return (i == 0) ? 10 : 3;      endfunction
    function automatic int pstall(int i); return (i == 0) ? 0 : 4;       endfunction
    function automatic int paddr(int i);  return (i == 0) ? 0 : 1;       endfunction
    function automatic int pmod(int i);   return (i == 0) ? 65536 : 16;  endfunction

    typedef struct {
        int rdy, packs, flits, src, ea, el, es, ep, dn;
    } obs_t;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    // reference model state, packet-level view
    int m_in [2], m_k [2], m_packs [2], m_flits [2], m_src [2];
    int m_ea [2], m_el [2], m_es [2], m_ep [2], m_dn [2], m_t [2];
    bit took [2];
    obs_t q0 [$];
    obs_t q1 [$];

    task automatic chk(string nm, int i, int a, int e);
        nchk++;
        if (a != e) begin
            nfail++;
            $display("FAIL %s[%0d] at %0t: got %0d, required %0d", nm, i, $time, a, e);
        end
    endtask

    function automatic int m_ready(int i);
        if (pstall(i) == 0) return 1;
        return ((m_t[i] % pstall(i)) != pstall(i) - 1) ? 1 : 0;
    endfunction

    function automatic obs_t m_obs(int i);
        obs_t o;
        o.rdy = m_ready(i); o.packs = m_packs[i]; o.flits = m_flits[i]; o.src = m_src[i];
        o.ea = m_ea[i]; o.el = m_el[i]; o.es = m_es[i]; o.ep = m_ep[i]; o.dn = m_dn[i];
        return o;
    endfunction

    function automatic obs_t act(int i);
        obs_t o;
        o.rdy = int'(rdy_o[i]);
        o.packs = (i == 0) ? int'(packs_a) : int'(packs_b);
        o.flits = (i == 0) ? int'(flits_a) : int'(flits_b);
        o.src = int'(src_o[i]); o.ea = int'(ea_o[i]); o.el = int'(el_o[i]);
        o.es = int'(es_o[i]); o.ep = int'(ep_o[i]); o.dn = int'(dn_o[i]);
        return o;
    endfunction

    task automatic m_reset(int i);
        m_in[i] = 0; m_k[i] = 0; m_packs[i] = 0; m_flits[i] = 0; m_src[i] = 0;
        m_ea[i] = 0; m_el[i] = 0; m_es[i] = 0; m_ep[i] = 0; m_dn[i] = 0; m_t[i] = 0;
    endtask

    task automatic m_flit(int i, logic [5:0] d);
        int ty, pl;
        ty = int'(d[5:4]);
        pl = int'(d[3:0]);
        m_flits[i] = (m_flits[i] + 1) % pmod(i);
        if (ty == 1 || ty == 3) begin
            if (m_in[i] != 0) m_ep[i] = 1;
            m_src[i] = (pl >> 1) & 1;
            if ((pl & 1) != paddr(i)) m_ea[i] = 1;
            m_k[i] = 0;
            if (ty == 3) begin
                m_in[i] = 0;
                m_packs[i] = (m_packs[i] + 1) % pmod(i);
            end else begin
                m_in[i] = 1;
            end
        end else if (m_in[i] == 0) begin
            m_ep[i] = 1;
        end else begin
            m_k[i]++;
            if (m_k[i] + 1 > pmax(i)) m_el[i] = 1;
            if (pl != m_k[i] % 16) m_es[i] = 1;
            if (ty == 2) begin
                m_in[i] = 0;
                m_packs[i] = (m_packs[i] + 1) % pmod(i);
            end
        end
        if (m_packs[i] >= 10) m_dn[i] = 1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (a_rst) begin
                m_reset(i);
                took[i] = 1'b0;
            end else begin
                took[i] = rv[i] && (m_ready(i) == 1);
                if (took[i]) m_flit(i, dat[i]);
                m_t[i] = (pstall(i) == 0) ? 0 : (m_t[i] + 1) % pstall(i);
            end
            if (i == 0) q0.push_back(m_obs(0));
            else        q1.push_back(m_obs(1));
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            obs_t e, a;
            if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                a = act(i);
                chk("wr_ready_out", i, a.rdy, e.rdy);
                chk("packs_cnt", i, a.packs, e.packs);
                chk("flits_cnt", i, a.flits, e.flits);
                chk("last_src", i, a.src, e.src);
                chk("err_addr", i, a.ea, e.ea);
                chk("err_len", i, a.el, e.el);
                chk("err_seq", i, a.es, e.es);
                chk("err_proto", i, a.ep, e.ep);
                chk("done", i, a.dn, e.dn);
            end
        end
    end

    task automatic send(int i, int ty, int pl);
        int n;
        n = 0;
        dat[i] = 6'(((ty & 3) << 4) | (pl & 15));
        rv[i] = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!took[i] && n < 30);
        if (!took[i]) begin
            nchk++;
            nfail++;
            $display("FAIL handshake[%0d]: no accept after %0d cycles, required an accept", i, n);
        end
    endtask

    task automatic idle(int i, int n);
        rv[i] = 1'b0;
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    task automatic do_reset();
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        @(negedge clk);
        #2 a_rst = 1'b1;
        @(negedge clk);
        #2 a_rst = 1'b0;
    endtask

    function automatic int rand_hdr(int i);
        int dest, src;
        dest = ($urandom_range(0, 3) == 0) ? (1 - paddr(i)) : paddr(i);
        src  = int'($urandom_range(0, 1));
        return (int'($urandom_range(0, 3)) << 2) | (src << 1) | dest;
    endfunction

    task automatic rand_traffic(int i, int n);
        int r, nb, pl;
        for (int p = 0; p < n; p++) begin
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                send(i, int'($urandom_range(0, 1)) * 2, int'($urandom_range(0, 15)));
            end else if (r < 6) begin
                send(i, 3, rand_hdr(i));
            end else begin
                send(i, 1, rand_hdr(i));
                nb = int'($urandom_range(0, pmax(i) + 1));
                for (int b = 1; b <= nb; b++) begin
                    pl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : b % 16;
                    send(i, 0, pl);
                end
                if ($urandom_range(0, 19) != 0) send(i, 2, (nb + 1) % 16);
            end
            if ($urandom_range(0, 3) == 0) idle(i, int'($urandom_range(1, 3)));
        end
        idle(i, 0);
    endtask

    initial begin
        int c0;
        a_rst = 1'b1;
        rv[0] = 1'b0; rv[1] = 1'b0;
        dat[0] = '0;  dat[1] = '0;

        // clean packet, no stall: 4 flits in 4 cycles
        do_reset();
        c0 = cyc;
        send(0, 1, 2); send(0, 0, 1); send(0, 0, 2); send(0, 2, 3);
        chk("t1_cycles", 0, cyc - c0, 4);
        chk("t1_packs", 0, int'(packs_a), 1);
        chk("t1_flits", 0, int'(flits_a), 4);
        chk("t1_src", 0, int'(src_o[0]), 1);
        chk("t1_errs", 0, int'({ea_o[0], el_o[0], es_o[0], ep_o[0]}), 0);
        idle(0, 1);

        // single with wrong destination, FSM must stay IDLE
        do_reset();
        send(0, 3, 1);
        chk("t2_packs", 0, int'(packs_a), 1);
        chk("t2_err_addr", 0, int'(ea_o[0]), 1);
        send(0, 0, 1);
        chk("t2_idle_proto", 0, int'(ep_o[0]), 1);
        idle(0, 1);

        // over-length packet on the short-limit instance
        do_reset();
        send(1, 1, 1); send(1, 0, 1); send(1, 0, 2); send(1, 2, 3);
        chk("t3_err_len", 1, int'(el_o[1]), 1);
        chk("t3_packs", 1, int'(packs_b), 1);
        chk("t3_err_seq", 1, int'(es_o[1]), 0);
        idle(1, 1);

        // bad sequence, then lone body in IDLE
        do_reset();
        send(0, 1, 0); send(0, 0, 1); send(0, 0, 5); send(0, 2, 3);
        idle(0, 0);
        chk("t4_err_seq", 0, int'(es_o[0]), 1);
        chk("t4_proto_pre", 0, int'(ep_o[0]), 0);
        send(0, 0, 4);
        idle(0, 0);
        chk("t4_err_proto", 0, int'(ep_o[0]), 1);
        chk("t4_flits", 0, int'(flits_a), 5);
        chk("t4_packs", 0, int'(packs_a), 1);

        // stall every 4th cycle: 10 singles need 13 cycles
        do_reset();
        c0 = cyc;
        for (int j = 0; j < 10; j++) begin
            send(1, 3, 1);
            if (j == 8) chk("t5_done_early", 1, int'(dn_o[1]), 0);
        end
        chk("t5_cycles", 1, cyc - c0, 13);
        chk("t5_done", 1, int'(dn_o[1]), 1);
        chk("t5_packs", 1, int'(packs_b), 10);
        idle(1, 1);

        // async reset mid-packet, then orphan tail
        do_reset();
        send(0, 1, 2); send(0, 0, 1);
        idle(0, 0);
        @(negedge clk);
        #2 a_rst = 1'b1;
        #1;
        chk("t6_rst_flits", 0, int'(flits_a), 0);
        chk("t6_rst_src", 0, int'(src_o[0]), 0);
        chk("t6_rst_ready", 0, int'(rdy_o[0]), 1);
        chk("t6_rst_ready_b", 1, int'(rdy_o[1]), 1);
        @(negedge clk);
        #2 a_rst = 1'b0;
        send(0, 2, 2);
        idle(0, 0);
        chk("t6_err_proto", 0, int'(ep_o[0]), 1);
        chk("t6_packs", 0, int'(packs_a), 0);
        chk("t6_flits", 0, int'(flits_a), 1);

        // random traffic, periodic reset so sticky flags stay informative
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 2; i++) rand_traffic(i, 30);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
